// File: rtl/strided_addr_gen_pkg.sv
// Shared types and default widths for the strided 2-D address generator.
package strided_addr_gen_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DIM_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sag_state_e;

endpackage

// File: rtl/stride_counter.sv
// Index counter paired with an address accumulator. Each enable advances the
// index and adds step to the value; on reaching limit it wraps the index to 0
// and reloads the value from wrap_val. A load takes priority over an enable.
module stride_counter #(
  parameter int ADDR_W = 16,
  parameter int DIM_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_val,
  input  logic [ADDR_W-1:0] step,
  input  logic [ADDR_W-1:0] wrap_val,
  input  logic              en,
  input  logic [DIM_W-1:0]  limit,
  output logic [ADDR_W-1:0] val,
  output logic [DIM_W-1:0]  idx,
  output logic              wrap
);

  logic [ADDR_W-1:0] val_q, val_d;
  logic [DIM_W-1:0]  idx_q, idx_d;

  // wrap means the next enable returns the index to 0
  assign wrap = (idx_q == limit);
  assign val  = val_q;
  assign idx  = idx_q;

  // next value: load, wrap-reload, or step
  always_comb begin
    val_d = val_q;
    idx_d = idx_q;
    if (load) begin
      val_d = load_val;
      idx_d = '0;
    end else if (en) begin
      if (wrap) begin
        val_d = wrap_val;
        idx_d = '0;
      end else begin
        val_d = val_q + step;
        idx_d = idx_q + DIM_W'(1);
      end
    end
  end

  // value/index registers
  always_ff @(posedge clock) begin
    if (reset) begin
      val_q <= '0;
      idx_q <= '0;
    end else begin
      val_q <= val_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/strided_addr_gen.sv
// Strided 2-D address generator: walks rows x cols row-major, emitting
// base + r*row_stride + c*col_stride over a valid/ready handshake.
// Optional build macro STRIDED_ADDR_GEN_REPEAT_EN adds the rpt input: when it
// is sampled high with start the tile repeats forever (exit only by reset).
// The port is named rpt because repeat is a reserved word.
module strided_addr_gen
  import strided_addr_gen_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DIM_W  = DEF_DIM_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [DIM_W-1:0]  rows,
  input  logic [DIM_W-1:0]  cols,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic [ADDR_W-1:0] col_stride,
`ifdef STRIDED_ADDR_GEN_REPEAT_EN
  input  logic              rpt,
`endif
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic [DIM_W-1:0]  row_idx,
  output logic [DIM_W-1:0]  col_idx,
  output logic              last,
  output logic              busy,
  output logic              done
);

  sag_state_e state_q, state_d;

  logic [ADDR_W-1:0] base_q, base_d;
  logic [DIM_W-1:0]  rows_q, rows_d;
  logic [DIM_W-1:0]  cols_q, cols_d;
  logic [ADDR_W-1:0] rstride_q, rstride_d;
  logic [ADDR_W-1:0] cstride_q, cstride_d;
  logic              rpt_q;

  logic              launch;
  logic              xfer;
  logic              col_wrap, row_wrap;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] col_wrap_val;

  // only a start in IDLE with a non-empty tile launches a run
  assign launch = (state_q == ST_IDLE) && start && (rows != '0) && (cols != '0);
  assign xfer   = addr_valid && addr_ready;

`ifdef STRIDED_ADDR_GEN_REPEAT_EN
  logic rpt_d;

  // repeat flag captured alongside the configuration
  always_comb begin
    rpt_d = rpt_q;
    if (launch) rpt_d = rpt;
  end

  // repeat flag register
  always_ff @(posedge clock) begin
    if (reset) rpt_q <= 1'b0;
    else       rpt_q <= rpt_d;
  end
`else
  assign rpt_q = 1'b0;
`endif

  // configuration capture; inputs are ignored after the launch cycle
  always_comb begin
    base_d    = base_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    rstride_d = rstride_q;
    cstride_d = cstride_q;
    if (launch) begin
      base_d    = base;
      rows_d    = rows;
      cols_d    = cols;
      rstride_d = row_stride;
      cstride_d = col_stride;
    end
  end

  // configuration registers
  always_ff @(posedge clock) begin
    if (reset) begin
      base_q    <= '0;
      rows_q    <= '0;
      cols_q    <= '0;
      rstride_q <= '0;
      cstride_q <= '0;
    end else begin
      base_q    <= base_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      rstride_q <= rstride_d;
      cstride_q <= cstride_d;
    end
  end

  // At the end of a row the column counter reloads with the next row base;
  // at the end of the tile it reloads with base (used only when repeating).
  assign col_wrap_val = row_wrap ? base_q : (row_base + rstride_q);

  stride_counter #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_col (
    .clock    (clock),
    .reset    (reset),
    .load     (launch),
    .load_val (base),
    .step     (cstride_q),
    .wrap_val (col_wrap_val),
    .en       (xfer),
    .limit    (cols_q - DIM_W'(1)),
    .val      (addr),
    .idx      (col_idx),
    .wrap     (col_wrap)
  );

  stride_counter #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_row (
    .clock    (clock),
    .reset    (reset),
    .load     (launch),
    .load_val (base),
    .step     (rstride_q),
    .wrap_val (base_q),
    .en       (xfer && col_wrap),
    .limit    (rows_q - DIM_W'(1)),
    .val      (row_base),
    .idx      (row_idx),
    .wrap     (row_wrap)
  );

  // outputs decoded from registered state
  assign addr_valid = (state_q == ST_RUN);
  assign last       = addr_valid && row_wrap && col_wrap;
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = launch ? ST_RUN : ST_DONE;
      ST_RUN:  if (xfer && last && !rpt_q) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

endmodule

// File: tb/tb_strided_addr_gen.sv
// Scoreboard bench for strided_addr_gen (default build, ADDR_W=16, DIM_W=8).
module tb_strided_addr_gen;

  logic        clock = 1'b0;
  logic        reset, start, addr_ready;
  logic [15:0] base, row_stride, col_stride;
  logic [7:0]  rows, cols;
  logic        addr_valid, last, busy, done;
  logic [15:0] addr;
  logic [7:0]  row_idx, col_idx;

  always #5 clock = ~clock;

  strided_addr_gen dut (
    .clock(clock), .reset(reset), .start(start), .base(base), .rows(rows),
    .cols(cols), .row_stride(row_stride), .col_stride(col_stride),
    .addr_valid(addr_valid), .addr_ready(addr_ready), .addr(addr),
    .row_idx(row_idx), .col_idx(col_idx), .last(last), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  r;
    logic [7:0]  c;
    logic        l;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0, xfer_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push1(input logic [15:0] a, input int r, input int c, input bit l);
    exp_t e;
    e.a = a; e.r = 8'(r); e.c = 8'(c); e.l = l;
    sb.push_back(e);
  endtask

  // reference tile walk from the closed-form address formula
  task automatic push_model(input logic [15:0] b, input int nr, input int nc,
                            input logic [15:0] rs, input logic [15:0] cs);
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++)
        push1(16'(b + 16'(r) * rs + 16'(c) * cs), r, c, (r == nr-1) && (c == nc-1));
  endtask

  // monitor: pop on every transfer, check hold while stalled
  logic        prev_v = 1'b0, prev_r = 1'b0;
  logic [15:0] prev_a = '0;
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (addr_valid && prev_v && !prev_r) chk("addr_hold", addr, prev_a);
      if (addr_valid && addr_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_xfer: got addr %0h expected none", addr);
        end else begin
          e = sb.pop_front();
          chk("addr", addr, e.a);
          chk("row_idx", row_idx, e.r);
          chk("col_idx", col_idx, e.c);
          chk("last", last, e.l);
        end
        xfer_cnt++;
      end else if (addr_valid && sb.size() != 0) begin
        chk("last_stall", last, sb[0].l);
      end
    end
    prev_v = addr_valid && !reset;
    prev_r = addr_ready;
    prev_a = addr;
  end

  task automatic check_idle_zero(input string tag);
    chk({tag, "_valid"}, addr_valid, 0);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_row"}, row_idx, 0);
    chk({tag, "_col"}, col_idx, 0);
    chk({tag, "_last"}, last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic launch(input logic [15:0] b, input int nr, input int nc,
                        input logic [15:0] rs, input logic [15:0] cs);
    @(posedge clock); #1;
    start = 1'b1; base = b; rows = 8'(nr); cols = 8'(nc);
    row_stride = rs; col_stride = cs; addr_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    // scramble config: must not affect the run
    base = 16'hDEAD; rows = 8'd0; cols = 8'd7; row_stride = 16'h5555; col_stride = 16'h3333;
    chk("busy_after_start", busy, 1);
  endtask

  // run a launched tile until done; pat 1 gives ready 1,0,0,1,0,0...
  task automatic finish_tile(input string tag, input int pat, input int exp_n);
    int n = 0;
    while (n < 1200) begin
      addr_ready = (pat == 0) ? 1'b1 : ((n % 3) == 0);
      @(negedge clock);
      if (done) break;
      @(posedge clock); #1;
      n++;
    end
    if (n >= 1200) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no done expected done", tag);
    end
    if (exp_n >= 0) chk({tag, "_done_lat"}, n, exp_n);
    chk({tag, "_drained"}, sb.size(), 0);
    chk({tag, "_valid_in_done"}, addr_valid, 0);
    @(negedge clock);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  initial begin
    int x0;
    reset = 1'b1; start = 1'b0; addr_ready = 1'b0;
    base = '0; rows = '0; cols = '0; row_stride = '0; col_stride = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check_idle_zero("reset");

    // basic 2x3 tile, ready held high
    push1(16'h100, 0, 0, 0); push1(16'h101, 0, 1, 0); push1(16'h102, 0, 2, 0);
    push1(16'h110, 1, 0, 0); push1(16'h111, 1, 1, 0); push1(16'h112, 1, 2, 1);
    launch(16'h100, 2, 3, 16'h10, 16'h1);
    finish_tile("basic", 0, 6);

    // same tile with stalling consumer
    push1(16'h100, 0, 0, 0); push1(16'h101, 0, 1, 0); push1(16'h102, 0, 2, 0);
    push1(16'h110, 1, 0, 0); push1(16'h111, 1, 1, 0); push1(16'h112, 1, 2, 1);
    launch(16'h100, 2, 3, 16'h10, 16'h1);
    finish_tile("stall", 1, -1);

    // address wrap-around
    push1(16'hFFFE, 0, 0, 0); push1(16'hFFFF, 0, 1, 0);
    push1(16'h0000, 0, 2, 0); push1(16'h0001, 0, 3, 1);
    launch(16'hFFFE, 1, 4, 16'h0, 16'h1);
    finish_tile("wrap", 0, 4);

    // transposed access with stalls
    push_model(16'h0, 3, 2, 16'h1, 16'h40);
    launch(16'h0, 3, 2, 16'h1, 16'h40);
    finish_tile("transpose", 1, -1);

    // empty tile: straight to done, no address
    launch(16'h500, 0, 5, 16'h1, 16'h1);
    finish_tile("zero_rows", 0, 0);
    launch(16'h500, 3, 0, 16'h1, 16'h1);
    finish_tile("zero_cols", 0, 0);

    // maximum column count
    push_model(16'h2000, 2, 255, 16'h1000, 16'h3);
    launch(16'h2000, 2, 255, 16'h1000, 16'h3);
    finish_tile("max_cols", 0, 510);

    // mid-run start ignored, then reset after the 3rd transfer
    push_model(16'h40, 4, 4, 16'h20, 16'h2);
    x0 = xfer_cnt;
    launch(16'h40, 4, 4, 16'h20, 16'h2);
    start = 1'b1; base = 16'hBEEF; rows = 8'd1; cols = 8'd1;
    @(posedge clock); #1 start = 1'b0;
    for (int i = 0; i < 50 && (xfer_cnt - x0) < 3; i++) @(posedge clock);
    chk("pre_reset_xfers", xfer_cnt - x0, 3);
    #1 reset = 1'b1; addr_ready = 1'b0;
    @(posedge clock); #1;
    sb.delete();
    @(negedge clock);
    check_idle_zero("mid_reset");
    #1 reset = 1'b0;
    @(negedge clock);
    check_idle_zero("post_reset");

    // fresh run after reset
    push_model(16'h300, 4, 4, 16'h100, 16'h4);
    launch(16'h300, 4, 4, 16'h100, 16'h4);
    finish_tile("after_reset", 1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
